// File: rtl/seq_detector_param.sv
// Serial pattern detector: runtime-loadable pattern of 1..MAX_LEN bits,
// overlap/non-overlap modes, input qualifier and saturating match counter.
module seq_detector_param #(
   parameter int unsigned         MAX_LEN = 8,
   parameter int unsigned         CNT_W   = 8,
   parameter logic [MAX_LEN-1:0]  DEF_PAT = 8'b0000_0101,
   parameter int unsigned         DEF_LEN = 3,
   parameter logic                DEF_OVL = 1'b1,
   localparam int unsigned        LW      = $clog2(MAX_LEN + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               seq_in,
   input  logic               seq_valid,
   input  logic               pat_load,
   input  logic [MAX_LEN-1:0] pat_in,
   input  logic [LW-1:0]      pat_len,
   input  logic               ovl_in,
   input  logic               cnt_clr,
   output logic               det_o,
   output logic [CNT_W-1:0]   det_cnt,
   output logic               cnt_sat,
   output logic [LW-1:0]      fill_o
);

   logic [MAX_LEN-1:0] pat;
   logic [MAX_LEN-1:0] hist;
   logic [MAX_LEN-1:0] hist_next;
   logic [MAX_LEN-1:0] len_mask;
   logic [MAX_LEN-1:0] diff;
   logic [LW-1:0]      len;
   logic [LW-1:0]      len_clamp;
   logic [LW-1:0]      fill;
   logic [LW-1:0]      fill_inc;
   logic               ovl;
   logic               accept;
   logic               match;

   always_comb begin
      accept    = seq_valid & ~pat_load;
      hist_next = {hist[MAX_LEN-2:0], seq_in};
      fill_inc  = (fill == LW'(MAX_LEN)) ? fill : fill + 1'b1;
      len_clamp = (pat_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : pat_len;
      len_mask  = '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (LW'(i) < len);
      end
      // Only the newest len bits of the shifted history take part in the compare.
      diff  = (hist_next ^ pat) & len_mask;
      match = accept && (len != '0) && (fill_inc >= len) && (diff == '0);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         pat     <= DEF_PAT;
         len     <= LW'(DEF_LEN);
         ovl     <= DEF_OVL;
         hist    <= '0;
         fill    <= '0;
         det_o   <= 1'b0;
         det_cnt <= '0;
      end else begin
         det_o <= match;
         if (pat_load) begin
            pat  <= pat_in;
            len  <= len_clamp;
            ovl  <= ovl_in;
            fill <= '0;
         end else if (accept) begin
            hist <= hist_next;
            // Non-overlap: emptying fill forces len fresh bits before the next match.
            fill <= (match && !ovl) ? '0 : fill_inc;
         end
         if (cnt_clr) begin
            det_cnt <= match ? CNT_W'(1) : '0;
         end else if (match && !cnt_sat) begin
            det_cnt <= det_cnt + 1'b1;
         end
      end
   end

   assign cnt_sat = &det_cnt;
   assign fill_o  = fill;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed test-plan steps plus random traffic,
// every cycle compared against a queue-based model of the detection rules.
module tb_seq_detector_param;

   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned CNT_W   = 2;
   localparam int unsigned LW      = $clog2(MAX_LEN + 1);
   localparam int          CMAX    = (1 << CNT_W) - 1;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic               seq_in = 1'b0;
   logic               seq_valid = 1'b0;
   logic               pat_load = 1'b0;
   logic [MAX_LEN-1:0] pat_in = '0;
   logic [LW-1:0]      pat_len = '0;
   logic               ovl_in = 1'b0;
   logic               cnt_clr = 1'b0;
   logic               det_o;
   logic [CNT_W-1:0]   det_cnt;
   logic               cnt_sat;
   logic [LW-1:0]      fill_o;

   int total = 0;
   int bad   = 0;

   // Reference model: accepted bits since the last fill reset, oldest first.
   bit          q[$];
   logic [7:0]  m_pat;
   int          m_len;
   bit          m_ovl;
   bit          m_det;
   int          m_cnt;

   seq_detector_param #(
      .MAX_LEN(MAX_LEN),
      .CNT_W  (CNT_W)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .seq_in   (seq_in),
      .seq_valid(seq_valid),
      .pat_load (pat_load),
      .pat_in   (pat_in),
      .pat_len  (pat_len),
      .ovl_in   (ovl_in),
      .cnt_clr  (cnt_clr),
      .det_o    (det_o),
      .det_cnt  (det_cnt),
      .cnt_sat  (cnt_sat),
      .fill_o   (fill_o)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic bit model_match();
      if (m_len == 0 || q.size() < m_len) return 1'b0;
      for (int k = 0; k < m_len; k++) begin
         if (q[q.size() - m_len + k] != m_pat[m_len-1-k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_tick();
      bit m;
      m = 1'b0;
      if (!reset) begin
         m_pat = 8'h05; m_len = 3; m_ovl = 1'b1;
         q.delete();
         m_cnt = 0;
      end else begin
         if (pat_load) begin
            m_pat = pat_in;
            m_len = (int'(pat_len) > MAX_LEN) ? MAX_LEN : int'(pat_len);
            m_ovl = ovl_in;
            q.delete();
         end else if (seq_valid) begin
            q.push_back(seq_in);
            if (q.size() > MAX_LEN) void'(q.pop_front());
            m = model_match();
            if (m && !m_ovl) q.delete();
         end
         if (cnt_clr) m_cnt = m ? 1 : 0;
         else if (m && m_cnt < CMAX) m_cnt++;
      end
      m_det = m;
   endtask

   // One clock: drive inputs, take the edge, update model, compare all outputs.
   task automatic cyc(input logic r, input logic v, input logic b, input logic ld, input logic clr);
      reset = r; seq_valid = v; seq_in = b; pat_load = ld; cnt_clr = clr;
      @(posedge clock);
      #1;
      model_tick();
      check("det_o",   32'(det_o),   32'(m_det));
      check("det_cnt", 32'(det_cnt), 32'(m_cnt));
      check("cnt_sat", 32'(cnt_sat), 32'(m_cnt == CMAX));
      check("fill_o",  32'(fill_o),  32'(q.size()));
   endtask

   task automatic load(input logic [7:0] p, input int l, input logic o);
      pat_in = p; pat_len = LW'(l); ovl_in = o;
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic send(input string bits, input string exp);
      for (int i = 0; i < bits.len(); i++) begin
         cyc(1'b1, 1'b1, bits[i] == "1", 1'b0, 1'b0);
         check("det_seq", 32'(det_o), 32'(exp[i] == "1"));
      end
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         check("det_gap", 32'(det_o), 32'd0);
      end
   endtask

   initial begin
      // 1: defaults, overlapping 101
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rst_fill", 32'(fill_o), 32'd0);
      check("rst_cnt", 32'(det_cnt), 32'd0);
      send("0101011", "0001010");
      check("t1_cnt", 32'(det_cnt), 32'd2);

      // 2: non-overlap
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      load(8'h05, 3, 1'b0);
      send("10101101", "00100001");
      check("t2_cnt", 32'(det_cnt), 32'd2);

      // 3: valid gaps do not break a pattern
      send("1", "0");
      gap(3);
      send("0", "0");
      gap(1);
      send("1", "1");

      // 4: mid-stream reset
      send("10", "00");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send("1", "0");
      check("t4_fill", 32'(fill_o), 32'd1);
      check("t4_cnt", 32'(det_cnt), 32'd0);
      send("01", "01");

      // 5: full length, disable, dropped bit on load
      load(8'hA5, 8, 1'b1);
      send("10100101", "00000001");
      check("t5_fill", 32'(fill_o), 32'd8);
      load(8'hA5, 0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 1'b1, 1'($urandom), 1'b0, 1'b0);
         check("t5_dis", 32'(det_o), 32'd0);
      end
      pat_in = 8'h05; pat_len = LW'(3); ovl_in = 1'b1;
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      check("t5_drop", 32'(fill_o), 32'd0);

      // 6: saturating counter
      load(8'h01, 1, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         send("1", "1");
         check("t6_cnt", 32'(det_cnt), 32'((i < 3) ? i + 1 : 3));
         check("t6_sat", 32'(cnt_sat), 32'(i >= 2));
      end
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      check("t6_clr_cnt", 32'(det_cnt), 32'd1);
      check("t6_clr_sat", 32'(cnt_sat), 32'd0);

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         logic r, v, b, ld, clr;
         r   = ($urandom_range(0, 149) != 0);
         v   = ($urandom_range(0, 3) != 0);
         b   = 1'($urandom);
         clr = ($urandom_range(0, 29) == 0);
         ld  = ($urandom_range(0, 39) == 0);
         if (ld) begin
            pat_in  = 8'($urandom);
            pat_len = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(5, 15))
                                                   : LW'($urandom_range(0, 4));
            ovl_in  = 1'($urandom);
         end
         cyc(r, v, b, ld, clr);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial pattern detector. It generalises the fixed 3-bit "101" detector to a runtime-loadable pattern of 1..MAX_LEN bits, with selectable overlapping or non-overlapping detection. It adds an input-valid qualifier and a saturating match counter. It sits on a serial bit stream and flags every occurrence of the programmed pattern to downstream control logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2).
CNT_W, 8, width of match counter.
DEF_PAT, 8'b0000_0101, pattern loaded at reset (LSB-aligned).
DEF_LEN, 3, pattern length loaded at reset.
DEF_OVL, 1, overlap mode loaded at reset (1 = overlapping).

Ports:
clock  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset.
seq_in  in  1  serial data bit.
seq_valid  in  1  seq_in is sampled only when high.
pat_load  in  1  latches pat_in, pat_len and ovl_in this cycle.
pat_in  in  MAX_LEN  pattern. Bit pat_len-1 is the first bit received; bit 0 is the last bit received.
pat_len  in  $clog2(MAX_LEN+1)  pattern length.
ovl_in  in  1  overlap mode to latch.
cnt_clr  in  1  clears match counter.
det_o  out  1  registered one-cycle match pulse.
det_cnt  out  CNT_W  number of matches, saturating.
cnt_sat  out  1  high while det_cnt is all-ones.
fill_o  out  $clog2(MAX_LEN+1)  valid history bits held, saturates at MAX_LEN.

Behaviour:
- Reset is sampled on the clock edge while reset==0. It loads pat=DEF_PAT, len=DEF_LEN, ovl=DEF_OVL. It clears hist, fill, det_o, det_cnt and cnt_sat to 0. Reset has priority over every other input.
- History register: hist[MAX_LEN-1:0]. On an accepted bit, hist <= {hist[MAX_LEN-2:0], seq_in} and fill <= min(fill+1, MAX_LEN).
- Match is evaluated on the updated history: match = (len != 0) && (fill_next >= len) && (hist_next[len-1:0] == pat[len-1:0]).
- det_o <= match, so det_o is high in the cycle after the clock edge that sampled the last pattern bit.
  - Latency is one clock from that sample.
  - det_o is never high for two cycles from a single bit.
  - det_o is 0 in any cycle following a non-accepted bit.
- Overlap mode (ovl=1): history is kept after a match. Example: with "101", stream 10101 matches at bits 3 and 5.
- Non-overlap mode (ovl=0): on a match, fill <= 0 and hist is kept but ignored. The next match needs len fresh bits.
- seq_valid low: hist, fill and det pattern are unchanged, and det_o <= 0. Gaps do not break a pattern.
- pat_load=1 (reset inactive):
  - Latches pat_in, ovl_in, and len = min(pat_len, MAX_LEN).
  - Clears fill to 0 and drives det_o <= 0.
  - Ignores seq_valid in the same cycle; that bit is dropped.
  - Does not change det_cnt.
- len==0 disables detection. Bits are still shifted, and det_o stays 0.
- Counter update on a match:
  - If det_cnt is all-ones, it holds (saturates); otherwise det_cnt <= det_cnt+1.
  - cnt_clr alone sets det_cnt <= 0.
  - cnt_clr and match in the same cycle set det_cnt <= 1.
  - cnt_sat is derived combinationally from det_cnt == all-ones.
- Implementation is shift-register based, not a hand-coded FSM, so any len up to MAX_LEN is supported without RTL change.
- All outputs are registered except cnt_sat.

Test Plan:
1. Defaults after reset (101, len 3, overlap). Send valid bits 0,1,0,1,0,1,1, one per cycle. Required: det_o pulses one cycle after bit 4 and after bit 6, is 0 elsewhere, and det_cnt==2.
2. Non-overlap mode. pat_load with pat_in=8'h05, pat_len=3, ovl_in=0, then send 1,0,1,0,1,1,0,1. Required: det_o after bit 3 and bit 8 only, and det_cnt==2.
3. Valid gaps. Send 1, then seq_valid=0 for 3 cycles, then 0, then seq_valid=0 for 1 cycle, then 1. Required: exactly one det_o pulse, one cycle after the final 1, and det_o==0 during the gaps.
4. Mid-stream reset. Send 1,0, drive reset=0 for one cycle, then send 1. Required: no det_o, fill_o==1 after the last bit, and det_cnt==0. Then send 0,1. Required: det_o after the final 1.
5. Full length and disable. Load pat_in=8'hA5, pat_len=8, send 10100101. Required: det_o after bit 8, and fill_o==8. Then load pat_len=0 and send any 16 bits. Required: det_o stays 0. Also a pat_load coinciding with seq_valid=1 drops that bit: fill_o==0.
6. Counter (CNT_W=2). Load pat_in=1, pat_len=1, overlap, then send five 1s. Required: det_cnt sequence 1,2,3,3,3, and cnt_sat high from the third match. Then assert cnt_clr together with a matching bit. Required: det_cnt==1 and cnt_sat==0.
